ifu_fetch: RTL and testbench

- Instruction fetch stage of the RV64 pipeline.
- Owns the PC and runs a req/ack handshake with instruction memory (64-bit words).
- Extracts the 32-bit instruction and presents a registered {instruction, address, valid} triple to the IF/ID pipeline register.
- Honours the ctrl stall (hold) and EX-stage jump redirect; jump squashes any in-flight fetch.

---
 rtl/ifu_fetch.sv | 119 +++++++++++
 tb/tb_ifu_fetch.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the PC, runs the req/ack handshake with
// instruction memory and presents a registered {inst, addr, valid} triple
// to the IF/ID pipeline register.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | one cycle after reset, no request yet
// S_FETCH | request outstanding at {pc[63:3],3'b0}
// S_STALL | instruction captured under hold; request parked until release
module ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [63:0] NOP_INST = 64'h0000_0000_0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [63:0] jump_addr_i,
    input  logic        hold_flag_i,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [63:0] imem_rdata_i,
    output logic [63:0] inst_o,
    output logic [63:0] inst_addr_o,
    output logic        inst_valid_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic [63:0] r_inst;
    logic [63:0] r_inst_addr;
    logic        r_inst_valid;

    state_t      w_state_nxt;
    logic [63:0] w_pc_nxt;
    logic [63:0] w_inst_nxt;
    logic [63:0] w_inst_addr_nxt;
    logic        w_inst_valid_nxt;
    logic [31:0] w_word;

    // Request is decoded from state only, so reset drops it without a clock edge.
    assign imem_req_o   = (r_state == S_FETCH);
    assign imem_addr_o  = {r_pc[63:3], 3'b000};
    assign inst_o       = r_inst;
    assign inst_addr_o  = r_inst_addr;
    assign inst_valid_o = r_inst_valid;

    assign w_word = r_pc[2] ? imem_rdata_i[63:32] : imem_rdata_i[31:0];

    // Next-state and next-output decode; jump overrides everything, including hold.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_inst_nxt       = r_inst;
        w_inst_addr_nxt  = r_inst_addr;
        w_inst_valid_nxt = r_inst_valid;

        if (jump_en_i) begin
            w_pc_nxt         = jump_addr_i;
            w_inst_valid_nxt = 1'b0;
            w_inst_nxt       = NOP_INST;
            w_state_nxt      = S_FETCH;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack_i) begin
                        // Captured data is kept even when hold arrives with the ack.
                        w_inst_nxt       = {32'b0, w_word};
                        w_inst_addr_nxt  = r_pc;
                        w_inst_valid_nxt = 1'b1;
                        w_pc_nxt         = r_pc + 64'd4;
                        w_state_nxt      = hold_flag_i ? S_STALL : S_FETCH;
                    end else if (!hold_flag_i) begin
                        w_inst_valid_nxt = 1'b0;
                        w_inst_nxt       = NOP_INST;
                    end
                end
                S_STALL: begin
                    // IF/ID takes the held instruction on the release edge.
                    if (!hold_flag_i) begin
                        w_inst_valid_nxt = 1'b0;
                        w_inst_nxt       = NOP_INST;
                        w_state_nxt      = S_FETCH;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State, PC and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_inst       <= NOP_INST;
            r_inst_addr  <= 64'd0;
            r_inst_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_inst       <= w_inst_nxt;
            r_inst_addr  <= w_inst_addr_nxt;
            r_inst_valid <= w_inst_valid_nxt;
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with hand-computed expectations.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        jump_en_i;
    logic [63:0] jump_addr_i;
    logic        hold_flag_i;
    logic        imem_req_o;
    logic [63:0] imem_addr_o;
    logic        imem_ack_i;
    logic [63:0] imem_rdata_i;
    logic [63:0] inst_o;
    logic [63:0] inst_addr_o;
    logic        inst_valid_o;

    int n_vec;
    int n_miss;

    localparam logic [63:0] NOP = 64'h13;

    ifu_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .hold_flag_i  (hold_flag_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .inst_o       (inst_o),
        .inst_addr_o  (inst_addr_o),
        .inst_valid_o (inst_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [63:0] inst,
                           input logic [63:0] addr, input logic valid);
        chk({tag, ".inst"},  inst_o,       inst);
        chk({tag, ".iaddr"}, inst_addr_o,  addr);
        chk({tag, ".valid"}, {63'b0, inst_valid_o}, {63'b0, valid});
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [63:0] addr);
        chk({tag, ".req"}, {63'b0, imem_req_o}, {63'b0, req});
        if (req) chk({tag, ".maddr"}, imem_addr_o, addr);
    endtask

    initial begin
        n_vec        = 0;
        n_miss       = 0;
        rst          = 1'b0;
        jump_en_i    = 1'b0;
        jump_addr_i  = 64'd0;
        hold_flag_i  = 1'b0;
        imem_ack_i   = 1'b1;
        imem_rdata_i = {32'h00200093, 32'h00100093};

        tick();
        chk_req("rst", 1'b0, 64'd0);
        chk_out("rst", NOP, 64'd0, 1'b0);
        #3 rst = 1'b1;

        // IDLE -> FETCH, first request
        tick();
        chk_req("c1", 1'b1, 64'h8000_0000);
        chk_out("c1", NOP, 64'd0, 1'b0);

        tick();
        chk_out("c2", 64'h00100093, 64'h8000_0000, 1'b1);
        chk_req("c2", 1'b1, 64'h8000_0000);

        tick();
        chk_out("c3", 64'h00200093, 64'h8000_0004, 1'b1);
        chk_req("c3", 1'b1, 64'h8000_0008);

        // delayed ack at 0x80000008
        imem_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_req("wait", 1'b1, 64'h8000_0008);
            chk_out("wait", NOP, 64'h8000_0004, 1'b0);
        end
        imem_ack_i = 1'b1;
        tick();
        chk_out("dly", 64'h00100093, 64'h8000_0008, 1'b1);

        // hold coincident with ack at 0x8000000C
        hold_flag_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_req("stall", 1'b0, 64'd0);
            chk_out("stall", 64'h00200093, 64'h8000_000C, 1'b1);
        end
        hold_flag_i = 1'b0;
        tick();
        chk_out("rel", NOP, 64'h8000_000C, 1'b0);
        chk_req("rel", 1'b1, 64'h8000_0010);

        tick();
        chk_out("f10", 64'h00100093, 64'h8000_0010, 1'b1);

        // jump coincident with ack at 0x80000014 under hold
        hold_flag_i = 1'b1;
        jump_en_i   = 1'b1;
        jump_addr_i = 64'h8000_1000;
        tick();
        chk_out("jmp", NOP, 64'h8000_0010, 1'b0);
        chk_req("jmp", 1'b1, 64'h8000_1000);

        // async reset during an unacknowledged request
        jump_en_i   = 1'b0;
        hold_flag_i = 1'b0;
        imem_ack_i  = 1'b0;
        tick();
        chk_req("pre_rst", 1'b1, 64'h8000_1000);
        #2 rst = 1'b0;
        #1;
        chk_req("arst", 1'b0, 64'd0);
        chk_out("arst", NOP, 64'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk_req("restart", 1'b1, 64'h8000_0000);

        // wrap-around jump
        imem_rdata_i = {32'h00300093, 32'h00400093};
        imem_ack_i   = 1'b1;
        jump_en_i    = 1'b1;
        jump_addr_i  = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        jump_en_i = 1'b0;
        chk_req("wrapj", 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        chk_out("wrapj", NOP, 64'd0, 1'b0);
        tick();
        chk_out("wrap0", 64'h00300093, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        chk_req("wrap0", 1'b1, 64'd0);
        tick();
        chk_out("wrap1", 64'h00400093, 64'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
